// File: rtl/sopc_data_bus_if.sv
// CPU-to-slave data bus signal bundle. The slave modport is the bus controller's
// view (CPU request in, slave strobes out); master is the surrounding CPU/slave side.
interface sopc_data_bus_if #(
  parameter int NUM_SLAVES = 2
);
  logic                        cpu_ce_i;
  logic                        cpu_we_i;
  logic [31:0]                 cpu_addr_i;
  logic [3:0]                  cpu_sel_i;
  logic [31:0]                 cpu_data_i;
  logic [31:0]                 cpu_data_o;
  logic                        cpu_stall_o;
  logic                        cpu_err_o;
  logic [NUM_SLAVES-1:0]       s_ce_o;
  logic                        s_we_o;
  logic [31:0]                 s_addr_o;
  logic [3:0]                  s_sel_o;
  logic [31:0]                 s_data_o;
  logic [NUM_SLAVES-1:0][31:0] s_data_i;
  logic [NUM_SLAVES-1:0]       s_ack_i;

  modport slave (
    input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i, s_data_i, s_ack_i,
    output cpu_data_o, cpu_stall_o, cpu_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o
  );

  modport master (
    output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i, s_data_i, s_ack_i,
    input  cpu_data_o, cpu_stall_o, cpu_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o
  );
endinterface

// File: rtl/sopc_data_bus.sv
// Single-outstanding CPU data bus: decodes addr[31:28] to a one-hot slave enable and waits for ack.
// Optional BUSY timeout abort is compiled in with `define SOPC_BUS_TIMEOUT_EN.
module sopc_data_bus #(
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  sopc_data_bus_if.slave bus
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_slaves
    $error("sopc_data_bus: NUM_SLAVES out of range 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sopc_data_bus: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;

  state_t                r_state, w_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_s_we;
  logic [31:0]           r_s_addr, r_s_data, r_cpu_data;
  logic [3:0]            r_s_sel;
  logic                  w_hit, w_ack, w_tmo, w_accept;
  logic                  w_stall, w_err;
  logic [NUM_SLAVES-1:0] w_ce;

  // Compare in 5 bits so NUM_SLAVES=16 decodes every index as valid.
  assign w_hit    = ({1'b0, bus.cpu_addr_i[31:28]} < 5'(NUM_SLAVES));
  assign w_ack    = bus.s_ack_i[r_idx];
  assign w_accept = (r_state == S_IDLE) && bus.cpu_ce_i && w_hit;

`ifdef SOPC_BUS_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // Counter value TIMEOUT_CYCLES-1 here means it reaches TIMEOUT_CYCLES on this edge.
  assign w_tmo = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                              r_tmo_cnt <= '0;
    else if (w_accept)                    r_tmo_cnt <= '0;
    else if (r_state == S_BUSY && !w_ack) r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_stall = bus.cpu_ce_i;
        if (bus.cpu_ce_i) w_next = w_hit ? S_BUSY : S_ERR;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_ack)      w_next = S_DONE;
        else if (w_tmo) w_next = S_ERR;
      end
      S_DONE: w_next = S_IDLE;
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_ce
    assign w_ce[k] = (r_state == S_BUSY) && (r_idx == IDX_W'(k));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_sel    <= '0;
      r_s_data   <= '0;
      r_cpu_data <= '0;
    end else begin
      if (w_accept) begin
        r_idx    <= bus.cpu_addr_i[28 +: IDX_W];
        r_s_we   <= bus.cpu_we_i;
        r_s_addr <= bus.cpu_addr_i;
        r_s_sel  <= bus.cpu_sel_i;
        r_s_data <= bus.cpu_data_i;
      end
      if (w_next == S_ERR)
        r_cpu_data <= '0;
      else if (r_state == S_BUSY && w_ack && !r_s_we)
        r_cpu_data <= bus.s_data_i[r_idx];
    end
  end

  assign bus.s_ce_o      = w_ce;
  assign bus.s_we_o      = r_s_we;
  assign bus.s_addr_o    = r_s_addr;
  assign bus.s_sel_o     = r_s_sel;
  assign bus.s_data_o    = r_s_data;
  assign bus.cpu_data_o  = r_cpu_data;
  assign bus.cpu_stall_o = w_stall;
  assign bus.cpu_err_o   = w_err;
endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed bench for sopc_data_bus: reset, read, write with waits, decode error,
// back-to-back, timeout (or indefinite wait), and reset during BUSY.
module tb_sopc_data_bus;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sopc_data_bus_if #(.NUM_SLAVES(2)) bus ();

  sopc_data_bus #(.NUM_SLAVES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cpu_ce_i   = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_sel_i  = '0;
    bus.cpu_data_i = '0;
    bus.s_ack_i    = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.s_data_i = '0;
    tick();
    tick();
    n_run++; if (bus.s_ce_o !== 2'b00) begin n_fail++; $display("FAIL rst_ce: got %b exp 00", bus.s_ce_o); end
    n_run++; if ({bus.s_we_o, bus.s_addr_o, bus.s_sel_o, bus.s_data_o} !== 69'd0) begin
      n_fail++; $display("FAIL rst_sbus: got we=%b a=%h s=%b d=%h exp zeros", bus.s_we_o, bus.s_addr_o, bus.s_sel_o, bus.s_data_o); end
    n_run++; if (bus.cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", bus.cpu_data_o); end
    n_run++; if ({bus.cpu_err_o, bus.cpu_stall_o} !== 2'b00) begin n_fail++; $display("FAIL rst_err_stall: got %b exp 00", {bus.cpu_err_o, bus.cpu_stall_o}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read;
    bus.s_data_i[0] = 32'h1111_1111;
    bus.s_data_i[1] = 32'hDEAD_BEEF;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1000_0004; bus.cpu_sel_i = 4'hF;
    #1;
    n_run++; if (bus.cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL rd_idle_stall: got %b exp 1", bus.cpu_stall_o); end
    tick();
    n_run++; if (bus.s_ce_o !== 2'b10) begin n_fail++; $display("FAIL rd_busy_ce: got %b exp 10", bus.s_ce_o); end
    n_run++; if (bus.s_addr_o !== 32'h1000_0004 || bus.s_we_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_busy_req: got a=%h we=%b exp 10000004/0", bus.s_addr_o, bus.s_we_o); end
    bus.s_ack_i = 2'b10;
    tick();
    bus.s_ack_i = 2'b00;
    n_run++; if (bus.cpu_stall_o !== 1'b0 || bus.s_ce_o !== 2'b00) begin
      n_fail++; $display("FAIL rd_done_stall_ce: got stall=%b ce=%b exp 0/00", bus.cpu_stall_o, bus.s_ce_o); end
    n_run++; if (bus.cpu_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_done_data: got %h exp deadbeef", bus.cpu_data_o); end
    bus.cpu_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_write;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h0000_0010;
    bus.cpu_sel_i = 4'b0011; bus.cpu_data_i = 32'h1234_5678;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_run++; if (bus.s_ce_o !== 2'b01 || bus.cpu_stall_o !== 1'b1) begin
        n_fail++; $display("FAIL wr_busy%0d: got ce=%b stall=%b exp 01/1", i, bus.s_ce_o, bus.cpu_stall_o); end
      n_run++; if (bus.s_we_o !== 1'b1 || bus.s_sel_o !== 4'b0011 || bus.s_data_o !== 32'h1234_5678) begin
        n_fail++; $display("FAIL wr_req%0d: got we=%b sel=%b d=%h exp 1/0011/12345678", i, bus.s_we_o, bus.s_sel_o, bus.s_data_o); end
      // Cycle 1 carries an ack from the unselected slave, which must not complete.
      bus.s_ack_i = (i == 3) ? 2'b01 : (i == 1) ? 2'b10 : 2'b00;
      tick();
    end
    bus.s_ack_i = 2'b00;
    n_run++; if (bus.cpu_stall_o !== 1'b0 || bus.s_ce_o !== 2'b00) begin
      n_fail++; $display("FAIL wr_done: got stall=%b ce=%b exp 0/00", bus.cpu_stall_o, bus.s_ce_o); end
    n_run++; if (bus.cpu_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_data_hold: got %h exp deadbeef", bus.cpu_data_o); end
    bus.cpu_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_decode_err;
    logic [31:0] addrs [3];
    addrs[0] = 32'h3000_0000; addrs[1] = 32'h2000_0000; addrs[2] = 32'hF000_0008;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = addrs[i];
      #1;
      n_run++; if (bus.cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL err%0d_stall_idle: got %b exp 1", i, bus.cpu_stall_o); end
      tick();
      n_run++; if (bus.cpu_err_o !== 1'b1 || bus.s_ce_o !== 2'b00 || bus.cpu_stall_o !== 1'b0) begin
        n_fail++; $display("FAIL err%0d_state: got err=%b ce=%b stall=%b exp 1/00/0", i, bus.cpu_err_o, bus.s_ce_o, bus.cpu_stall_o); end
      n_run++; if (bus.cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL err%0d_data: got %h exp 0", i, bus.cpu_data_o); end
      bus.cpu_ce_i = 1'b0;
      tick();
      n_run++; if (bus.cpu_err_o !== 1'b0 || bus.s_ce_o !== 2'b00) begin
        n_fail++; $display("FAIL err%0d_pulse: got err=%b ce=%b exp 0/00", i, bus.cpu_err_o, bus.s_ce_o); end
    end
  endtask

  task automatic test_back_to_back;
    bus.s_data_i[0] = 32'hA5A5_0001;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0020; bus.cpu_sel_i = 4'hF;
    tick();
    bus.s_ack_i = 2'b01;
    tick();
    bus.s_ack_i = 2'b00;
    bus.s_data_i[0] = 32'hA5A5_0002;
    #1;
    n_run++; if (bus.cpu_data_o !== 32'hA5A5_0001 || bus.cpu_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done1: got d=%h stall=%b exp a5a50001/0", bus.cpu_data_o, bus.cpu_stall_o); end
    tick();
    n_run++; if (bus.cpu_stall_o !== 1'b1 || bus.s_ce_o !== 2'b00) begin
      n_fail++; $display("FAIL b2b_idle: got stall=%b ce=%b exp 1/00", bus.cpu_stall_o, bus.s_ce_o); end
    tick();
    n_run++; if (bus.s_ce_o !== 2'b01) begin n_fail++; $display("FAIL b2b_busy2: got %b exp 01", bus.s_ce_o); end
    bus.s_ack_i = 2'b01;
    tick();
    bus.s_ack_i = 2'b00;
    n_run++; if (bus.cpu_data_o !== 32'hA5A5_0002 || bus.cpu_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done2: got d=%h stall=%b exp a5a50002/0", bus.cpu_data_o, bus.cpu_stall_o); end
    bus.cpu_ce_i = 1'b0;
    tick();
  endtask

`ifdef SOPC_BUS_TIMEOUT_EN
  task automatic test_timeout;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1000_0000;
    tick();
    for (int i = 1; i <= 8; i++) begin
      n_run++; if (bus.s_ce_o !== 2'b10 || bus.cpu_stall_o !== 1'b1) begin
        n_fail++; $display("FAIL tmo_busy%0d: got ce=%b stall=%b exp 10/1", i, bus.s_ce_o, bus.cpu_stall_o); end
      tick();
    end
    n_run++; if (bus.cpu_err_o !== 1'b1 || bus.s_ce_o !== 2'b00 || bus.cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL tmo_err: got err=%b ce=%b d=%h exp 1/00/0", bus.cpu_err_o, bus.s_ce_o, bus.cpu_data_o); end
    tick();
    bus.s_data_i[1] = 32'hCAFE_F00D;
    tick();
    for (int i = 1; i < 8; i++) tick();
    bus.s_ack_i = 2'b10;
    tick();
    bus.s_ack_i = 2'b00;
    n_run++; if (bus.cpu_err_o !== 1'b0 || bus.cpu_stall_o !== 1'b0 || bus.cpu_data_o !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL tmo_ack_wins: got err=%b stall=%b d=%h exp 0/0/cafef00d", bus.cpu_err_o, bus.cpu_stall_o, bus.cpu_data_o); end
    bus.cpu_ce_i = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout;
    int bad = 0;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1000_0000;
    bus.s_data_i[1] = 32'hCAFE_F00D;
    tick();
    for (int i = 0; i < 300; i++) begin
      if (bus.s_ce_o !== 2'b10 || bus.cpu_stall_o !== 1'b1 || bus.cpu_err_o !== 1'b0) bad++;
      tick();
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL wait_forever: got %0d bad BUSY cycles exp 0", bad); end
    bus.s_ack_i = 2'b10;
    tick();
    bus.s_ack_i = 2'b00;
    n_run++; if (bus.cpu_stall_o !== 1'b0 || bus.cpu_data_o !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL wait_done: got stall=%b d=%h exp 0/cafef00d", bus.cpu_stall_o, bus.cpu_data_o); end
    bus.cpu_ce_i = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_busy;
    bus.s_data_i[0] = 32'h7777_7777;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0008;
    tick();
    bus.s_ack_i = 2'b10;
    tick();
    n_run++; if (bus.s_ce_o !== 2'b01 || bus.cpu_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL rb_spurious: got ce=%b stall=%b exp 01/1", bus.s_ce_o, bus.cpu_stall_o); end
    bus.s_ack_i = 2'b01;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.s_ack_i = 2'b00;
    bus.cpu_ce_i = 1'b0;
    #1;
    n_run++; if (bus.s_ce_o !== 2'b00 || bus.cpu_err_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rb_after_rst: got ce=%b err=%b stall=%b exp 00/0/0", bus.s_ce_o, bus.cpu_err_o, bus.cpu_stall_o); end
    n_run++; if (bus.cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL rb_data: got %h exp 0", bus.cpu_data_o); end
    tick();
    n_run++; if (bus.s_ce_o !== 2'b00 || bus.cpu_err_o !== 1'b0 || bus.cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL rb_no_followup: got ce=%b err=%b d=%h exp 00/0/0", bus.s_ce_o, bus.cpu_err_o, bus.cpu_data_o); end
    bus.s_data_i[1] = 32'h1357_9BDF;
    bus.cpu_ce_i = 1'b1; bus.cpu_addr_i = 32'h1000_0040;
    tick();
    n_run++; if (bus.s_ce_o !== 2'b10) begin n_fail++; $display("FAIL rb_next_busy: got %b exp 10", bus.s_ce_o); end
    bus.s_ack_i = 2'b10;
    tick();
    bus.s_ack_i = 2'b00;
    n_run++; if (bus.cpu_data_o !== 32'h1357_9BDF || bus.cpu_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rb_next_done: got d=%h stall=%b exp 13579bdf/0", bus.cpu_data_o, bus.cpu_stall_o); end
    bus.cpu_ce_i = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_back_to_back();
`ifdef SOPC_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
